// File: rtl/pc_pkg.sv
// pc_pkg: shared types, default vectors and helpers
// for the IF-stage program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

    // Widest PC the helper handles; callers resize.
    localparam int unsigned PC_MAX_W = 64;

    // Clear the low log2(instrBytes) bits of an address.
    function automatic logic [PC_MAX_W-1:0] pc_align(
        input logic [PC_MAX_W-1:0] addr,
        input int unsigned         instrBytes
    );
        return addr & ~(PC_MAX_W'(instrBytes) - PC_MAX_W'(1));
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority mux choosing the next fetch
// address, pending-buffer updates and misalignment.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(DEF_EXC_VEC),
    parameter int unsigned      INSTR_BYTES = 4
) (
    input  pc_state_t        state,
    input  logic [WIDTH-1:0] currPC,
    input  logic             pendValid,
    input  logic [WIDTH-1:0] pendPc,
    input  logic             stall,
    input  logic             redirectValid,
    input  logic [WIDTH-1:0] redirectTarget,
    input  logic             excValid,
    input  logic             halt,
    output logic [WIDTH-1:0] nextPc,
    output logic             pendLoad,
    output logic             pendClear,
    output logic [WIDTH-1:0] pendData,
    output logic             epcLoad,
    output logic             misFlag
);

    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(INSTR_BYTES);

    logic [WIDTH-1:0] alignedTgt;
    logic             tgtMis;

    assign alignedTgt = WIDTH'(pc_align(PC_MAX_W'(redirectTarget),
                                        INSTR_BYTES));
    assign tgtMis     = |(redirectTarget & LOW_MASK);
    assign pendData   = alignedTgt;

    // Priority selection of the next PC for the current state.
    always_comb begin
        nextPc    = currPC;
        pendLoad  = 1'b0;
        pendClear = 1'b0;
        epcLoad   = 1'b0;
        misFlag   = 1'b0;
        unique case (state)
            BOOT: begin
                nextPc = currPC;
            end
            RUN: begin
                if (excValid) begin
                    epcLoad   = 1'b1;
                    nextPc    = EXC_VEC;
                    pendClear = 1'b1;
                end else if (halt) begin
                    nextPc = currPC;
                end else if (redirectValid && !stall) begin
                    nextPc    = alignedTgt;
                    pendClear = 1'b1;
                    misFlag   = tgtMis;
                end else if (redirectValid) begin
                    pendLoad = 1'b1;
                    misFlag  = tgtMis;
                end else if (stall) begin
                    nextPc = currPC;
                end else if (pendValid) begin
                    nextPc    = pendPc;
                    pendClear = 1'b1;
                end else begin
                    nextPc = currPC + STEP;
                end
            end
            HALTED: begin
                if (excValid) begin
                    epcLoad   = 1'b1;
                    nextPc    = EXC_VEC;
                    pendClear = 1'b1;
                end else if (redirectValid) begin
                    pendLoad = 1'b1;
                    misFlag  = tgtMis;
                end
            end
            default: begin
                nextPc = currPC;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with stall,
// redirect buffer, exception capture and halt.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(DEF_EXC_VEC),
    parameter int unsigned      INSTR_BYTES = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_valid,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] currPC,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] epc,
    output logic             misaligned
);

    pc_state_t        state;
    pc_state_t        nextState;
    logic             pendValid;
    logic [WIDTH-1:0] pendPc;
    logic [WIDTH-1:0] nextPc;
    logic             pendLoad;
    logic             pendClear;
    logic [WIDTH-1:0] pendData;
    logic             epcLoad;
    logic             misFlag;

    pc_next_sel #(
        .WIDTH      (WIDTH),
        .EXC_VEC    (EXC_VEC),
        .INSTR_BYTES(INSTR_BYTES)
    ) u_sel (
        .state         (state),
        .currPC        (currPC),
        .pendValid     (pendValid),
        .pendPc        (pendPc),
        .stall         (stall),
        .redirectValid (redirect_valid),
        .redirectTarget(redirect_target),
        .excValid      (exc_valid),
        .halt          (halt),
        .nextPc        (nextPc),
        .pendLoad      (pendLoad),
        .pendClear     (pendClear),
        .pendData      (pendData),
        .epcLoad       (epcLoad),
        .misFlag       (misFlag)
    );

    // Run-state transitions; an exception always lands in RUN.
    always_comb begin
        nextState = state;
        unique case (state)
            BOOT: begin
                nextState = RUN;
            end
            RUN: begin
                if (!exc_valid && halt) nextState = HALTED;
            end
            HALTED: begin
                if (exc_valid || resume) nextState = RUN;
            end
            default: begin
                nextState = BOOT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock_in) begin
        if (reset) state <= BOOT;
        else       state <= nextState;
    end

    // PC, EPC, pending redirect and registered status outputs.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            currPC      <= RESET_VEC;
            fetch_valid <= 1'b0;
            epc         <= '0;
            misaligned  <= 1'b0;
            pendValid   <= 1'b0;
            pendPc      <= '0;
        end else begin
            currPC      <= nextPc;
            fetch_valid <= (nextState == RUN);
            misaligned  <= misFlag;
            if (epcLoad) epc <= currPC;
            if (pendLoad) begin
                pendValid <= 1'b1;
                pendPc    <= pendData;
            end else if (pendClear) begin
                pendValid <= 1'b0;
            end
        end
    end

endmodule
